// File: rtl/order_manager.sv
// order_manager: turns registered buy/sell decisions into single orders on a
// valid/ready gateway interface, enforcing a signed position limit and an
// anti-churn cooldown. Tracks net position and counts lost decisions.
module order_manager #(
  parameter int data_width      = 8,
  parameter int qty_width       = 8,
  parameter int order_qty       = 1,
  parameter int max_position    = 4,
  parameter int cooldown_cycles = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig_valid,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [data_width-1:0] price,
  input  logic                  order_ready,
  output logic                  order_valid,
  output logic                  order_side,
  output logic [data_width-1:0] order_price,
  output logic [qty_width-1:0]  order_quantity,
  output logic [qty_width-1:0]  position,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  // Counter only needs to hold cooldown_cycles; keep at least one bit.
  localparam int CNT_W = (cooldown_cycles > 1) ? $clog2(cooldown_cycles + 1) : 1;

  // Limit arithmetic is done one bit wider than the position so the
  // candidate position can never wrap before it is compared.
  localparam logic signed [qty_width:0] QTY_S = (qty_width + 1)'(order_qty);
  localparam logic signed [qty_width:0] MAX_S = (qty_width + 1)'(max_position);

  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   side_q, side_d;
  logic [data_width-1:0]  price_q, price_d;
  logic [qty_width-1:0]   qty_q, qty_d;
  logic [qty_width-1:0]   position_q, position_d;
  logic [15:0]            drop_q, drop_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   decision;
  logic                   conflict;
  logic                   drop_inc;
  logic                   buy_ok;
  logic                   sell_ok;
  logic signed [qty_width:0] pos_ext;

  assign decision = sig_valid & (buy_signal ^ sell_signal);
  assign conflict = sig_valid & buy_signal & sell_signal;
  assign pos_ext  = {position_q[qty_width-1], position_q};
  assign buy_ok   = (pos_ext + QTY_S) <= MAX_S;
  assign sell_ok  = (pos_ext - QTY_S) >= -MAX_S;

  // Next-state logic: admission, handshake, cooldown and drop accounting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    side_d     = side_q;
    price_d    = price_q;
    qty_d      = qty_q;
    position_d = position_q;
    drop_inc   = conflict;

    case (state_q)
      IDLE: begin
        if (decision) begin
          if (buy_signal ? buy_ok : sell_ok) begin
            side_d  = buy_signal;
            price_d = price;
            qty_d   = qty_width'(order_qty);
            state_d = ISSUE;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (decision) drop_inc = 1'b1;
        if (valid_q && order_ready) begin
          position_d = side_q ? (position_q + qty_q) : (position_q - qty_q);
          if (cooldown_cycles == 0) begin
            state_d = IDLE;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = CNT_W'(cooldown_cycles);
          end
        end
      end
      COOLDOWN: begin
        if (decision) drop_inc = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    drop_d  = (drop_inc && (drop_q != 16'hFFFF)) ? (drop_q + 16'd1) : drop_q;
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      side_q     <= 1'b0;
      price_q    <= '0;
      qty_q      <= '0;
      position_q <= '0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      side_q     <= side_d;
      price_q    <= price_d;
      qty_q      <= qty_d;
      position_q <= position_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign order_valid    = valid_q;
  assign order_side     = side_q;
  assign order_price    = price_q;
  assign order_quantity = qty_q;
  assign position       = position_q;
  assign drop_count     = drop_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_order_manager.sv
// Scoreboard bench for order_manager. Three instances (cooldown 16, 0, 3)
// share stimulus; sel chooses which one the checks observe.
module tb_order_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_valid = 1'b0;
  logic       buy_signal = 1'b0;
  logic       sell_signal = 1'b0;
  logic [7:0] price = 8'd0;
  logic       order_ready = 1'b0;

  logic       ov [3];
  logic       os [3];
  logic [7:0] op [3];
  logic [7:0] oq [3];
  logic [7:0] pos [3];
  logic [15:0] dc [3];
  logic       bz [3];

  int sel = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       side;
    logic [7:0] price;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  order_manager #(.cooldown_cycles(16)) u_cd16 (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .buy_signal(buy_signal),
    .sell_signal(sell_signal), .price(price), .order_ready(order_ready),
    .order_valid(ov[0]), .order_side(os[0]), .order_price(op[0]),
    .order_quantity(oq[0]), .position(pos[0]), .drop_count(dc[0]), .busy(bz[0]));

  order_manager #(.cooldown_cycles(0)) u_cd0 (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .buy_signal(buy_signal),
    .sell_signal(sell_signal), .price(price), .order_ready(order_ready),
    .order_valid(ov[1]), .order_side(os[1]), .order_price(op[1]),
    .order_quantity(oq[1]), .position(pos[1]), .drop_count(dc[1]), .busy(bz[1]));

  order_manager #(.cooldown_cycles(3)) u_cd3 (
    .clk(clk), .rst(rst), .sig_valid(sig_valid), .buy_signal(buy_signal),
    .sell_signal(sell_signal), .price(price), .order_ready(order_ready),
    .order_valid(ov[2]), .order_side(os[2]), .order_price(op[2]),
    .order_quantity(oq[2]), .position(pos[2]), .drop_count(dc[2]), .busy(bz[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // One-cycle decision strobe; returns just after the sampling edge.
  task automatic decide(input logic b, input logic s, input logic [7:0] p);
    sig_valid   = 1'b1;
    buy_signal  = b;
    sell_signal = s;
    price       = p;
    tick();
    sig_valid   = 1'b0;
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
  endtask

  task automatic do_reset(input int s);
    rst = 1'b1;
    sel = s;
    sig_valid = 1'b0;
    buy_signal = 1'b0;
    sell_signal = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic push(input logic side, input logic [7:0] p);
    exp_t e;
    e.side  = side;
    e.price = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake the DUT presents must match the oldest expected order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ov[sel] && order_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_order: got side %0d price %0d expected none (t=%0t)",
                   os[sel], op[sel], $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hs_side", int'(os[sel]), int'(e.side));
          chk("hs_price", int'(op[sel]), int'(e.price));
          chk("hs_qty", int'(oq[sel]), 1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset(0);
    at_neg();
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_side", int'(os[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_price", int'(op[0]), 0);
    chk("rst_qty", int'(oq[0]), 0);
    chk("rst_pos", int'(pos[0]), 0);
    chk("rst_drop", int'(dc[0]), 0);

    // Reset then buy, cooldown 16
    order_ready = 1'b1;
    push(1'b1, 8'd100);
    decide(1'b1, 1'b0, 8'd100);
    at_neg();
    chk("buy_valid", int'(ov[0]), 1);
    chk("buy_side", int'(os[0]), 1);
    chk("buy_price", int'(op[0]), 100);
    chk("buy_busy", int'(bz[0]), 1);
    tick();
    for (int i = 0; i < 16; i++) begin
      at_neg();
      if (i == 0) begin
        chk("buy_valid_drop", int'(ov[0]), 0);
        chk("buy_pos", int'($signed(pos[0])), 1);
      end
      chk("cool_busy", int'(bz[0]), 1);
      tick();
    end
    at_neg();
    chk("cool_end_busy", int'(bz[0]), 0);

    // Backpressure: sell held 6 cycles while price moves
    do_reset(0);
    order_ready = 1'b0;
    push(1'b0, 8'd50);
    decide(1'b0, 1'b1, 8'd50);
    price = 8'd77;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_side", int'(os[0]), 0);
      chk("bp_price", int'(op[0]), 50);
      tick();
    end
    order_ready = 1'b1;
    at_neg();
    chk("bp_valid6", int'(ov[0]), 1);
    chk("bp_price6", int'(op[0]), 50);
    tick();
    at_neg();
    chk("bp_valid_after", int'(ov[0]), 0);
    chk("bp_pos", int'($signed(pos[0])), -1);

    // Position limit, cooldown 0
    do_reset(1);
    order_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      if (b < 4) push(1'b1, 8'(10 + b));
      decide(1'b1, 1'b0, 8'(10 + b));
      at_neg();
      chk("lim_valid", int'(ov[1]), (b < 4) ? 1 : 0);
      tick();
      tick();
    end
    at_neg();
    chk("lim_pos", int'($signed(pos[1])), 4);
    chk("lim_drop", int'(dc[1]), 2);

    // Cooldown 0: decision in handshake cycle dropped, next cycle accepted
    do_reset(1);
    order_ready = 1'b1;
    push(1'b1, 8'd40);
    decide(1'b1, 1'b0, 8'd40);
    decide(1'b1, 1'b0, 8'd41);
    at_neg();
    chk("cd0_hs_drop", int'(dc[1]), 1);
    chk("cd0_idle_valid", int'(ov[1]), 0);
    push(1'b1, 8'd42);
    decide(1'b1, 1'b0, 8'd42);
    at_neg();
    chk("cd0_next_valid", int'(ov[1]), 1);
    tick();
    at_neg();
    chk("cd0_pos", int'($signed(pos[1])), 2);

    // Busy and conflict drops, cooldown 16
    do_reset(0);
    order_ready = 1'b1;
    push(1'b1, 8'd30);
    decide(1'b1, 1'b0, 8'd30);
    tick();
    decide(1'b1, 1'b0, 8'd31);
    at_neg();
    chk("busy_drop", int'(dc[0]), 1);
    chk("busy_valid", int'(ov[0]), 0);
    repeat (20) tick();
    at_neg();
    chk("busy_idle", int'(bz[0]), 0);
    decide(1'b1, 1'b1, 8'd32);
    at_neg();
    chk("conflict_drop", int'(dc[0]), 2);
    chk("conflict_valid", int'(ov[0]), 0);
    decide(1'b0, 1'b0, 8'd33);
    at_neg();
    chk("none_drop", int'(dc[0]), 2);
    chk("none_valid", int'(ov[0]), 0);

    // Reset mid-ISSUE
    do_reset(0);
    order_ready = 1'b1;
    push(1'b1, 8'd20);
    decide(1'b1, 1'b0, 8'd20);
    repeat (18) tick();
    decide(1'b1, 1'b1, 8'd21);
    at_neg();
    chk("mid_pre_drop", int'(dc[0]), 1);
    chk("mid_pre_pos", int'($signed(pos[0])), 1);
    order_ready = 1'b0;
    push(1'b1, 8'd22);
    decide(1'b1, 1'b0, 8'd22);
    at_neg();
    chk("mid_valid", int'(ov[0]), 1);
    rst = 1'b1;
    tick();
    at_neg();
    chk("mid_rst_valid", int'(ov[0]), 0);
    chk("mid_rst_pos", int'(pos[0]), 0);
    chk("mid_rst_drop", int'(dc[0]), 0);
    chk("mid_rst_busy", int'(bz[0]), 0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    order_ready = 1'b1;
    push(1'b1, 8'd23);
    decide(1'b1, 1'b0, 8'd23);
    at_neg();
    chk("mid_new_valid", int'(ov[0]), 1);
    chk("mid_new_price", int'(op[0]), 23);
    tick();
    at_neg();
    chk("mid_new_pos", int'($signed(pos[0])), 1);

    // Cooldown boundary, cooldown 3: handshake at M, strobes at M+3 and M+4
    do_reset(2);
    order_ready = 1'b1;
    push(1'b1, 8'd60);
    decide(1'b1, 1'b0, 8'd60);
    for (int c = 0; c < 3; c++) begin
      tick();
      at_neg();
      chk("cd3_busy", int'(bz[2]), 1);
    end
    decide(1'b1, 1'b0, 8'd61);
    at_neg();
    chk("cd3_m3_drop", int'(dc[2]), 1);
    chk("cd3_m3_valid", int'(ov[2]), 0);
    chk("cd3_m3_busy", int'(bz[2]), 0);
    push(1'b1, 8'd62);
    decide(1'b1, 1'b0, 8'd62);
    at_neg();
    chk("cd3_m4_valid", int'(ov[2]), 1);
    chk("cd3_m4_price", int'(op[2]), 62);
    tick();
    at_neg();
    chk("cd3_pos", int'($signed(pos[2])), 2);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
